// File: rtl/gf2m_233_reducer_if.sv
// Handshake bundle between the GF(2^233) multiplier, the reducer and its consumer.
// The reducer takes the slave side; the producer/consumer pair takes the master side.
interface gf2m_233_reducer_if #(
    parameter int unsigned M = 233,
    parameter int unsigned W = 466
);
    logic [W-1:0] prod;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] r;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   folds;

    modport slave (
        input  prod,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output r,
        output out_valid,
        output folds
    );

    modport master (
        output prod,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  r,
        input  out_valid,
        input  folds
    );
endinterface

// File: rtl/gf2m_233_reducer.sv
// Iterative reduction of a 466-bit carry-less product modulo x^233 + x^74 + 1.
// One trinomial fold per clock, early exit once the upper half is clear.
module gf2m_233_reducer #(
    parameter int unsigned M = 233,
    parameter int unsigned K = 74,
    parameter int unsigned W = 466
) (
    input logic                 clk,
    input logic                 rst,
    gf2m_233_reducer_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StFold, StDone} state_e;

    state_e         r_state;
    state_e         w_state_next;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   w_acc_next;
    logic [1:0]     r_cnt;
    logic [1:0]     w_cnt_next;
    logic [M-1:0]   r_res;
    logic [M-1:0]   w_res_next;
    logic [1:0]     r_folds;
    logic [1:0]     w_folds_next;

    logic [M-1:0]   w_hi;
    logic [M-1:0]   w_lo;
    logic [W-1:0]   w_hi_ext;
    logic [W-1:0]   w_fold;

    assign w_hi     = r_acc[W-1:M];
    assign w_lo     = r_acc[M-1:0];
    assign w_hi_ext = {{(W-M){1'b0}}, w_hi};
    // H << K spans at most M+K bits, so the W-bit shift never truncates.
    assign w_fold   = {{(W-M){1'b0}}, w_lo} ^ w_hi_ext ^ (w_hi_ext << K);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_folds <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_res   <= w_res_next;
            r_folds <= w_folds_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_res_next   = r_res;
        w_folds_next = r_folds;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_acc_next   = bus.prod;
                    w_cnt_next   = 2'd0;
                    w_state_next = StFold;
                end
            end
            StFold: begin
                if (w_hi == '0) begin
                    w_res_next   = w_lo;
                    w_folds_next = r_cnt;
                    w_state_next = StDone;
                end else begin
                    w_acc_next = w_fold;
                    if (r_cnt != 2'd2) begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Held low while rst is asserted so no operand is offered during reset.
    assign bus.in_ready  = (r_state == StIdle) && !rst;
    assign bus.out_valid = (r_state == StDone);
    assign bus.r         = r_res;
    assign bus.folds     = r_folds;

endmodule
